// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - line field positions, FSM states and reset contents for the 2-way cache.
package cache_pkg;

  localparam int LINE_W    = 12;
  localparam int TAG_W     = 4;
  localparam int DAT_W     = 5;
  localparam int L_VALID   = 11;
  localparam int L_LRU     = 10;
  localparam int L_DIRTY   = 9;
  localparam int L_TAG_HI  = 8;
  localparam int L_TAG_LO  = 5;
  localparam int L_DATA_HI = 4;
  localparam int L_DATA_LO = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WRITEBACK,
    ST_FILL,
    ST_UPDATE,
    ST_RESP
  } state_t;

  localparam logic [LINE_W-1:0] RST_S0_W0 = 12'h800;
  localparam logic [LINE_W-1:0] RST_S0_W1 = 12'h821;
  localparam logic [LINE_W-1:0] RST_S1_W0 = 12'h842;
  localparam logic [LINE_W-1:0] RST_S1_W1 = 12'h863;

  // A freshly written line is always valid and most-recently used.
  function automatic logic [LINE_W-1:0] make_line(input logic dirty,
                                                  input logic [TAG_W-1:0] tag,
                                                  input logic [DAT_W-1:0] data);
    return {1'b1, 1'b1, dirty, tag, data};
  endfunction

endpackage

// File: rtl/cache_array_2x2.sv
// rtl/cache_array_2x2.sv - 2-set x 2-way line storage with tag compare and victim choice.
module cache_array_2x2
  import cache_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_index,
  input  logic [TAG_W-1:0]  i_tag,
  output logic              o_hit,
  output logic              o_hit_way,
  output logic [LINE_W-1:0] o_hit_line,
  output logic              o_victim_way,
  output logic              o_victim_dirty,
  output logic [TAG_W-1:0]  o_victim_tag,
  output logic [DAT_W-1:0]  o_victim_data,
  input  logic              i_wr_en,
  input  logic              i_wr_way,
  input  logic [LINE_W-1:0] i_wr_line
);

  logic [LINE_W-1:0] r_lines [2][2];
  logic [LINE_W-1:0] w_l0;
  logic [LINE_W-1:0] w_l1;
  logic              w_m0;
  logic              w_m1;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_lines[0][0] <= RST_S0_W0;
      r_lines[0][1] <= RST_S0_W1;
      r_lines[1][0] <= RST_S1_W0;
      r_lines[1][1] <= RST_S1_W1;
    end else if (i_wr_en) begin
      r_lines[i_index][i_wr_way]         <= i_wr_line;
      r_lines[i_index][~i_wr_way][L_LRU] <= 1'b0;
    end
  end

  assign w_l0 = r_lines[i_index][0];
  assign w_l1 = r_lines[i_index][1];
  assign w_m0 = w_l0[L_VALID] && (w_l0[L_TAG_HI:L_TAG_LO] == i_tag);
  assign w_m1 = w_l1[L_VALID] && (w_l1[L_TAG_HI:L_TAG_LO] == i_tag);

  assign o_hit      = w_m0 || w_m1;
  assign o_hit_way  = !w_m0 && w_m1;
  assign o_hit_line = o_hit_way ? w_l1 : w_l0;

  // Invalid way first, then the least-recent way; a tie falls to way 0.
  always_comb begin
    o_victim_way = 1'b0;
    if (!w_l0[L_VALID])                 o_victim_way = 1'b0;
    else if (!w_l1[L_VALID])            o_victim_way = 1'b1;
    else if (w_l0[L_LRU] == w_l1[L_LRU]) o_victim_way = 1'b0;
    else                                o_victim_way = w_l0[L_LRU];
  end

  assign o_victim_dirty = o_victim_way ? (w_l1[L_VALID] && w_l1[L_DIRTY])
                                       : (w_l0[L_VALID] && w_l0[L_DIRTY]);
  assign o_victim_tag   = o_victim_way ? w_l1[L_TAG_HI:L_TAG_LO] : w_l0[L_TAG_HI:L_TAG_LO];
  assign o_victim_data  = o_victim_way ? w_l1[L_DATA_HI:L_DATA_LO] : w_l0[L_DATA_HI:L_DATA_LO];

endmodule

// File: rtl/cache_ctrl_2vias.sv
// rtl/cache_ctrl_2vias.sv - write-back write-allocate 2-way cache controller FSM and memory handshake.
// Optional hit/miss statistics are built when CACHE_STATS_EN is defined.
module cache_ctrl_2vias
  import cache_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 5,
  parameter int STAT_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_hit,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [STAT_W-1:0] hit_count,
  output logic [STAT_W-1:0] miss_count
);

  state_t              r_state;
  state_t              w_next;
  logic                r_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_way;
  logic                r_hit;
  logic [DATA_W-1:0]   r_rdata;
  logic [DATA_W-1:0]   r_fill;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;

  logic                w_index;
  logic [TAG_W-1:0]    w_tag;
  logic                w_hit;
  logic                w_hit_way;
  logic [LINE_W-1:0]   w_hit_line;
  logic                w_victim_way;
  logic                w_victim_dirty;
  logic [TAG_W-1:0]    w_victim_tag;
  logic [DAT_W-1:0]    w_victim_data;
  logic                w_wr_en;
  logic                w_wr_way;
  logic [LINE_W-1:0]   w_wr_line;
  logic                w_mem_done;
  logic                w_mem_req_nxt;

  assign w_index    = r_addr[0];
  assign w_tag      = r_addr[ADDR_W-1:1];
  assign w_mem_done = r_mem_req && mem_ack;

  cache_array_2x2 u_array (
    .clock          (clock),
    .reset_n        (reset_n),
    .i_index        (w_index),
    .i_tag          (w_tag),
    .o_hit          (w_hit),
    .o_hit_way      (w_hit_way),
    .o_hit_line     (w_hit_line),
    .o_victim_way   (w_victim_way),
    .o_victim_dirty (w_victim_dirty),
    .o_victim_tag   (w_victim_tag),
    .o_victim_data  (w_victim_data),
    .i_wr_en        (w_wr_en),
    .i_wr_way       (w_wr_way),
    .i_wr_line      (w_wr_line)
  );

  always_comb begin
    w_next    = r_state;
    w_wr_en   = 1'b0;
    w_wr_way  = r_way;
    w_wr_line = w_hit_line;
    case (r_state)
      ST_IDLE:      if (req_valid) w_next = ST_LOOKUP;
      ST_LOOKUP: begin
        if (w_hit) begin
          w_wr_en          = 1'b1;
          w_wr_way         = w_hit_way;
          w_wr_line[L_LRU] = 1'b1;
          if (r_write) begin
            w_wr_line[L_DIRTY]               = 1'b1;
            w_wr_line[L_DATA_HI:L_DATA_LO]   = r_wdata;
          end
          w_next = ST_RESP;
        end else begin
          w_next = w_victim_dirty ? ST_WRITEBACK : ST_FILL;
        end
      end
      ST_WRITEBACK: if (w_mem_done) w_next = ST_FILL;
      ST_FILL:      if (w_mem_done) w_next = ST_UPDATE;
      ST_UPDATE: begin
        w_wr_en   = 1'b1;
        w_wr_line = make_line(r_write, w_tag, r_write ? r_wdata : r_fill);
        w_next    = ST_RESP;
      end
      ST_RESP:      w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
    // A completed transaction always leaves mem_req low for one cycle, even between write-back and fill.
    w_mem_req_nxt = ((w_next == ST_WRITEBACK) || (w_next == ST_FILL)) && !w_mem_done;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_way       <= 1'b0;
      r_hit       <= 1'b0;
      r_rdata     <= '0;
      r_fill      <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state   <= w_next;
      r_mem_req <= w_mem_req_nxt;
      if (r_state == ST_IDLE && req_valid) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (r_state == ST_LOOKUP) begin
        r_hit <= w_hit;
        if (w_hit) begin
          r_way   <= w_hit_way;
          r_rdata <= r_write ? r_wdata : w_hit_line[L_DATA_HI:L_DATA_LO];
        end else begin
          r_way      <= w_victim_way;
          r_mem_we   <= w_victim_dirty;
          r_mem_addr <= w_victim_dirty ? {w_victim_tag, w_index} : r_addr;
          if (w_victim_dirty) r_mem_wdata <= w_victim_data;
        end
      end
      if (r_state == ST_WRITEBACK && w_mem_done) begin
        r_mem_we   <= 1'b0;
        r_mem_addr <= r_addr;
      end
      if (r_state == ST_FILL && w_mem_done) r_fill <= mem_rdata;
      if (r_state == ST_UPDATE) r_rdata <= r_write ? r_wdata : r_fill;
    end
  end

`ifdef CACHE_STATS_EN
  logic [STAT_W-1:0] r_hit_cnt;
  logic [STAT_W-1:0] r_miss_cnt;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_state == ST_RESP) begin
      if (r_hit && r_hit_cnt != '1)        r_hit_cnt  <= r_hit_cnt + 1'b1;
      else if (!r_hit && r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = (r_state == ST_RESP);
  assign resp_hit   = (r_state == ST_RESP) && r_hit;
  assign resp_rdata = r_rdata;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

endmodule

// File: doc/cache_ctrl_2vias.md
CACHE_CTRL_2VIAS -- requirements
Module: cache_ctrl_2vias

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, meaning request/memory address width: tag = addr[4:1], index = addr[0].
REQ-002 SHALL have parameter DATA_W, default 5, meaning block data width.
REQ-003 SHALL have parameter STAT_W, default 8, meaning statistics counter width.
REQ-004 clock  in  1  single clock; all logic on posedge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 req_valid  in  1  CPU request present.
REQ-007 req_ready  out  1  controller can accept a request.
REQ-008 req_write  in  1  1 = write, 0 = read.
REQ-009 req_addr  in  ADDR_W  request address.
REQ-010 req_wdata  in  DATA_W  write data.
REQ-011 resp_valid  out  1  one-cycle response strobe.
REQ-012 resp_rdata  out  DATA_W  read data; for writes, the written value.
REQ-013 resp_hit  out  1  1 = request hit; qualified by resp_valid.
REQ-014 mem_req  out  1  memory transaction request, held until mem_ack.
REQ-015 mem_we  out  1  1 = write-back, 0 = fill.
REQ-016 mem_addr  out  ADDR_W  memory address.
REQ-017 mem_wdata  out  DATA_W  write-back data.
REQ-018 mem_ack  in  1  memory completes the current transaction this cycle.
REQ-019 mem_rdata  in  DATA_W  fill data, valid when mem_ack=1 and mem_we=0.
REQ-020 hit_count, miss_count  out  STAT_W each  statistics (see Configuration).

Function
REQ-021 SHALL own a 2-set x 2-way array of 12-bit lines: [11] valid, [10] lru, [9] dirty, [8:5] tag, [4:0] data.
REQ-022 FSM states SHALL be IDLE, LOOKUP, WRITEBACK, FILL, UPDATE, RESP; req_ready=1 only in IDLE.
REQ-023 Accept when req_valid&&req_ready: request fields latched, IDLE->LOOKUP; inputs ignored otherwise.
REQ-024 LOOKUP: hit on a valid way with matching tag; way 0 checked first. Hit read returns line data. Hit write stores req_wdata and sets dirty. Both go to RESP, so resp_valid is asserted 2 cycles after accept.
REQ-025 LRU: on any access to way w, line[w].lru=1 and the other way's lru=0. Victim selection: an invalid way first (way 0 preferred); otherwise the way with lru=0; if both lru are equal, way 0.
REQ-026 Miss with valid dirty victim SHALL go to WRITEBACK. There, mem_req=1, mem_we=1, mem_addr={victim tag, index}, mem_wdata=victim data, all held stable until mem_ack; then go to FILL.
REQ-027 Miss with clean or invalid victim SHALL go directly to FILL. There, mem_req=1, mem_we=0, mem_addr=latched req_addr, held until mem_ack; mem_rdata is captured on mem_ack, then go to UPDATE.
REQ-028 UPDATE SHALL install the victim line with valid=1, tag=req tag, dirty=req_write, data = req_write ? req_wdata : captured mem_rdata. It SHALL apply the LRU update, then go to RESP (write-allocate, write-back).
REQ-029 RESP SHALL assert resp_valid for exactly one cycle with resp_hit and resp_rdata, then return to IDLE. A new request is accepted no earlier than the cycle after RESP.
REQ-030 mem_req SHALL be deasserted in the cycle after mem_ack; a mem_ack arriving while mem_req=0 SHALL be ignored.

Reset
REQ-031 While reset_n=0 at a clock edge, outputs SHALL reset as follows: FSM->IDLE; req_ready=1; resp_valid, resp_hit, mem_req, mem_we=0; resp_rdata, mem_addr, mem_wdata=0; counters=0.
REQ-032 Reset SHALL reload the lines as follows: set0 way0 = valid, tag 0000, data 0; set0 way1 = valid, tag 0001, data 1; set1 way0 = valid, tag 0010, data 2; set1 way1 = valid, tag 0011, data 3. All lru and dirty bits SHALL be 0.
REQ-033 Reset during WRITEBACK or FILL SHALL abandon the transaction: mem_req=0 on the next cycle and no line is modified.

Configuration
REQ-034 With CACHE_STATS_EN defined, hit_count or miss_count SHALL increment by 1 at each RESP, saturating at 2^STAT_W-1. Without it, both ports SHALL exist and be tied to 0.

Structure
REQ-035 Package cache_pkg SHALL hold the line field bit positions, the FSM state enum, and the four reset line constants.
REQ-036 The line array, tag compare and victim selection SHALL live in sub-module cache_array_2x2; the FSM and memory handshake SHALL stay in cache_ctrl_2vias.

Verification
REQ-037 Post-reset read, addr 5'b00101: resp_valid 2 cycles after accept, resp_hit=1, rdata=2, mem_req never asserted.
REQ-038 Read addr 5'b00100 (miss, set0): victim way0 is clean, so no WRITEBACK; FILL with mem_addr=4; mem_ack after 3 cycles with rdata=0x15 -> resp_hit=0, rdata=0x15.
REQ-039 Write addr 0 with 0x1A (hit); read addr 2 (hit); read addr 6 (miss). The bench SHALL see WRITEBACK with mem_addr=0, mem_wdata=0x1A, then FILL with mem_addr=6.
REQ-040 reset_n=0 during FILL: mem_req=0 next cycle, req_ready=1; a subsequent read of addr 0 hits with rdata=0.
REQ-041 req_valid held high during a miss: no second accept until after RESP; req_ready=0 throughout.
REQ-042 With CACHE_STATS_EN, 300 read hits -> hit_count=255, miss_count=0.
